// File: rtl/sdp_ram_stream_reader.sv
// Burst read controller for a simple dual-port RAM: turns (addr, len) commands into a
// valid/ready beat stream, absorbing the fixed RAM read latency in a credit-tracked skid FIFO.
module sdp_ram_stream_reader #(
    parameter int DATA_W     = 64,
    parameter int RAM_DEPTH  = 512,
    parameter int LATENCY    = 2,
    parameter int FIFO_DEPTH = 4,
    localparam int AW        = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1,
    localparam int LEN_W     = AW + 1
) (
    input  logic              clka,
    input  logic              rstb,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [AW-1:0]     cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    output logic [AW-1:0]     ram_addrb,
    output logic              ram_enb,
    output logic              ram_rstb,
    input  logic [DATA_W-1:0] ram_doutb,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic              busy,
    output logic              done
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    generate
        if (LATENCY < 1 || FIFO_DEPTH < LATENCY + 2) begin : g_bad_cfg
            $error("sdp_ram_stream_reader: need LATENCY >= 1 and FIFO_DEPTH >= LATENCY+2");
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_e;
    typedef struct packed {
        logic              last;
        logic [DATA_W-1:0] data;
    } beat_t;

    state_e             state_q, state_d;
    logic [AW-1:0]      addr_q, addr_d;
    logic [LEN_W-1:0]   rem_q, rem_d;
    logic [LATENCY-1:0] vld_pipe_q, vld_pipe_d;
    logic [LATENCY-1:0] last_pipe_q, last_pipe_d;
    logic [CW-1:0]      count_q, count_d;
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic               cmd_ready_q, cmd_ready_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               ram_enb_q, ram_enb_d;
    beat_t              fifo_mem_q [FIFO_DEPTH];
    logic [CW-1:0]      inflight;
    logic               push, pop, issue;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        inflight = '0;
        for (int i = 0; i < LATENCY; i++) inflight = inflight + CW'(vld_pipe_q[i]);
        push = vld_pipe_q[LATENCY-1];
        pop  = (count_q != '0) && m_ready;
        // Credit: every in-flight read already owns a FIFO slot; a same-cycle pop is not counted.
        issue = (state_q == S_RUN) &&
                (({1'b0, count_q} + {1'b0, inflight}) < (CW+1)'(FIFO_DEPTH));

        vld_pipe_d[0]  = issue;
        last_pipe_d[0] = issue && (rem_q == LEN_W'(1));
        for (int i = 1; i < LATENCY; i++) begin
            vld_pipe_d[i]  = vld_pipe_q[i-1];
            last_pipe_d[i] = last_pipe_q[i-1];
        end

        count_d  = count_q + CW'(push) - CW'(pop);
        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;

        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    addr_d = cmd_addr;
                    rem_d  = cmd_len;
                    if (cmd_len != '0) state_d = S_RUN;
                    else               done_d  = 1'b1;
                end
            end
            S_RUN: begin
                if (issue) begin
                    addr_d = (addr_q == AW'(RAM_DEPTH - 1)) ? '0 : addr_q + AW'(1);
                    rem_d  = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (count_d == '0 && vld_pipe_d == '0) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // The done cycle itself refuses commands so the next burst starts one cycle later.
        cmd_ready_d = (state_d == S_IDLE) && !done_d;
        busy_d      = (state_d != S_IDLE);
        ram_enb_d   = busy_d;
    end

    always_ff @(posedge clka) begin
        if (rstb) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            rem_q       <= '0;
            vld_pipe_q  <= '0;
            last_pipe_q <= '0;
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ram_enb_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            vld_pipe_q  <= vld_pipe_d;
            last_pipe_q <= last_pipe_d;
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            ram_enb_q   <= ram_enb_d;
        end
    end

    always_ff @(posedge clka) begin
        if (push) fifo_mem_q[wr_ptr_q] <= '{last: last_pipe_q[LATENCY-1], data: ram_doutb};
    end

    assign cmd_ready = cmd_ready_q;
    assign ram_addrb = addr_q;
    assign ram_enb   = ram_enb_q;
    assign ram_rstb  = rstb;
    assign m_valid   = (count_q != '0);
    assign m_data    = fifo_mem_q[rd_ptr_q].data;
    assign m_last    = m_valid && fifo_mem_q[rd_ptr_q].last;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
